// File: rtl/fir_seq_ctrl_if.sv
// Bus between the FIR sequencer and its neighbours.
// Master side: the codec path driving samples and observing the sequencer.
// Slave side: the sequencer itself (queue write port, read address, FIR control, status).
interface fir_seq_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              vld;
  logic [15:0]       lft_in;
  logic [15:0]       rght_in;
  logic              wrt_en;
  logic [ADDR_W-1:0] wrt_addr;
  logic [15:0]       lft_wdata;
  logic [15:0]       rght_wdata;
  logic [ADDR_W-1:0] rd_addr;
  logic              sequencing;
  logic              done;
  logic              full;
  logic              busy;
  logic              ovr;

  modport master (
    output vld, lft_in, rght_in,
    input  wrt_en, wrt_addr, lft_wdata, rght_wdata, rd_addr,
    input  sequencing, done, full, busy, ovr
  );

  modport slave (
    input  vld, lft_in, rght_in,
    output wrt_en, wrt_addr, lft_wdata, rght_wdata, rd_addr,
    output sequencing, done, full, busy, ovr
  );
endinterface

// File: rtl/fir_seq_ctrl.sv
// FIR sample-queue sequencer.
// Writes each incoming stereo sample into a circular queue, then sweeps the
// queue oldest-to-newest while holding the FIR sequencing input for TAPS+1
// cycles, followed by a one-cycle done pulse.
// Build option: define FIR_SEQ_EARLY_EN to start a sweep on every accepted
// sample, before the queue is full (the queue RAM must then be zero-initialised).
//
// state | meaning
// IDLE  | waiting for a sample; writes are accepted only here
// SEQ   | sweeping the queue, sequencing high (counter 0..TAPS)
// DONE  | one-cycle done pulse, FIR outputs valid
module fir_seq_ctrl #(
  parameter int TAPS   = 1021,
  parameter int ADDR_W = 10
) (
  input logic         clk,
  input logic         rst,
  fir_seq_ctrl_if.slave bus
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0]     TAPS_C   = CW'(TAPS);
  localparam logic [CW-1:0]     LAST_CNT = CW'(TAPS - 1);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(TAPS - 1);

  typedef enum logic [1:0] {IDLE, SEQ, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [ADDR_W-1:0] rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]     count, count_nxt;
  logic [CW-1:0]     seq_cnt;
  logic              accept;
  logic              trigger;
  logic              full_q;
  logic              ovr_q;
  logic              seq_on;
  logic              done_on;

  // Write acceptance, pointer/count next values and sweep trigger
  always_comb begin
    accept     = bus.vld & (state == IDLE);
    wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + ADDR_W'(1);
    rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + ADDR_W'(1);
    count_nxt  = (count == TAPS_C) ? count : count + CW'(1);
`ifdef FIR_SEQ_EARLY_EN
    trigger    = accept;
`else
    trigger    = accept & (count_nxt == TAPS_C);
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and FIR control decode
  always_comb begin
    state_nxt = state;
    seq_on    = 1'b0;
    done_on   = 1'b0;
    case (state)
      IDLE: if (trigger) state_nxt = SEQ;
      SEQ: begin
        seq_on = 1'b1;
        if (seq_cnt == TAPS_C) state_nxt = DONE;
      end
      DONE: begin
        done_on   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Queue pointers, fill count and sweep counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      seq_cnt <= '0;
      full_q  <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr_nxt;
        count  <= count_nxt;
        full_q <= (count_nxt == TAPS_C);
      end
      if (trigger) begin
        // next write slot holds the oldest sample
        rd_ptr  <= wr_ptr_nxt;
        seq_cnt <= '0;
      end else if (state == SEQ) begin
        seq_cnt <= seq_cnt + CW'(1);
        // address stops on the newest entry for the final FIR cycle
        if (seq_cnt < LAST_CNT) rd_ptr <= rd_ptr_nxt;
      end
    end
  end

  // Sticky overrun: a sample arriving outside IDLE is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               ovr_q <= 1'b0;
    else if (bus.vld && (state != IDLE))   ovr_q <= 1'b1;
  end

  // Outputs; write port is forced quiet while reset is held
  always_comb begin
    bus.wrt_en     = accept & ~rst;
    bus.wrt_addr   = wr_ptr;
    bus.lft_wdata  = rst ? 16'h0000 : bus.lft_in;
    bus.rght_wdata = rst ? 16'h0000 : bus.rght_in;
    bus.rd_addr    = rd_ptr;
    bus.sequencing = seq_on;
    bus.done       = done_on;
    bus.full       = full_q;
    bus.busy       = (state != IDLE);
    bus.ovr        = ovr_q;
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl (TAPS=5, ADDR_W=3) with a queue RAM and
// an FIR model using 0x4000 on every tap.
module tb_fir_seq_ctrl;
  localparam int T  = 5;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_seq_ctrl_if #(.ADDR_W(AW)) bus ();

  fir_seq_ctrl #(.TAPS(T), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // external queue RAM (zero on reset) and FIR accumulator model
  logic signed [15:0] mem [0:(1<<AW)-1];
  logic signed [15:0] ram_q;
  logic               seq_prev;
  longint             acc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
      ram_q    <= '0;
      seq_prev <= 1'b0;
      acc      <= 0;
    end else begin
      if (bus.wrt_en) mem[bus.wrt_addr] <= bus.lft_wdata;
      ram_q    <= mem[bus.rd_addr];
      seq_prev <= bus.sequencing;
      if (bus.sequencing && !seq_prev) acc <= 0;
      else if (bus.sequencing)         acc <= acc + longint'(ram_q) * 16384;
    end
  end

  typedef struct { int addr; logic [15:0] l; logic [15:0] r; } wr_t;
  typedef struct { int start; int half_sum; } seq_t;

  wr_t  wq[$];
  seq_t sq[$];
  int   checks = 0;
  int   errors = 0;
  int   wp = 0;
  int   cnt = 0;
  int   seq_k = 0;
  int   sh [0:T-1];
  logic exp_full = 1'b0;
  logic exp_ovr  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    wr_t  w;
    seq_t s;
    int   k;
    logic exp_wr;
    exp_wr = (wq.size() > 0);
    chk("wrt_en", bus.wrt_en, exp_wr);
    if (exp_wr) begin
      w = wq.pop_front();
      if (bus.wrt_en) begin
        chk("wrt_addr", bus.wrt_addr, w.addr);
        chk("lft_wdata", bus.lft_wdata, w.l);
        chk("rght_wdata", bus.rght_wdata, w.r);
      end
    end
    chk("full", bus.full, exp_full);
    chk("ovr", bus.ovr, exp_ovr);
    if (bus.sequencing) begin
      if (seq_k == 0) chk("seq_expected", sq.size() > 0, 1'b1);
      if (sq.size() > 0) begin
        k = (seq_k < T - 1) ? seq_k : T - 1;
        chk("rd_addr", bus.rd_addr, (sq[0].start + k) % T);
      end
      chk("busy_seq", bus.busy, 1'b1);
      seq_k++;
    end else if (seq_k > 0) begin
      chk("done_after_seq", bus.done, 1'b1);
      chk("busy_done", bus.busy, 1'b1);
      chk("seq_len", seq_k, T + 1);
      if (sq.size() > 0) begin
        s = sq.pop_front();
        chk("fir_lft", acc >>> 15, longint'(s.half_sum));
      end
      seq_k = 0;
    end else begin
      chk("done_idle", bus.done, 1'b0);
    end
  endtask

  // one clock of stimulus; acc_exp says whether the sample should be written
  task automatic step(input logic v, input logic [15:0] l, input logic [15:0] r, input logic acc_exp);
    int   sum;
    logic set_ovr;
    set_ovr     = 1'b0;
    bus.vld     = v;
    bus.lft_in  = l;
    bus.rght_in = r;
    if (v && acc_exp) begin
      wq.push_back('{addr: wp, l: l, r: r});
      sh[wp] = int'($signed(l));
      wp = (wp + 1) % T;
      if (cnt < T) cnt++;
`ifdef FIR_SEQ_EARLY_EN
      if (1'b1) begin
`else
      if (cnt == T) begin
`endif
        sum = 0;
        for (int i = 0; i < T; i++) sum += sh[i];
        sq.push_back('{start: wp, half_sum: sum >>> 1});
      end
    end
    if (v && !acc_exp) set_ovr = 1'b1;
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    bus.vld  = 1'b0;
    exp_full = (cnt == T);
    if (set_ovr) exp_ovr = 1'b1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && (sq.size() > 0 || seq_k > 0 || bus.busy); i++)
      step(1'b0, 16'h0, 16'h0, 1'b0);
    chk("idle_timeout", sq.size() == 0 && seq_k == 0, 1'b1);
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    step(1'b1, l, r, 1'b1);
    wait_idle();
  endtask

  task automatic clear_model();
    wq.delete();
    sq.delete();
    wp = 0;
    cnt = 0;
    seq_k = 0;
    for (int i = 0; i < T; i++) sh[i] = 0;
    exp_full = 1'b0;
    exp_ovr  = 1'b0;
  endtask

  initial begin
    bus.vld = 1'b0;
    bus.lft_in = '0;
    bus.rght_in = '0;
    clear_model();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sequencing", bus.sequencing, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_full", bus.full, 1'b0);
    chk("rst_ovr", bus.ovr, 1'b0);
    chk("rst_wrt_en", bus.wrt_en, 1'b0);
    chk("rst_wrt_addr", bus.wrt_addr, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // fill, then the 5th sample completes the queue and starts a sweep
    for (int i = 1; i <= 4; i++) send(16'(i), 16'(100 + i));
    send(16'd5, 16'd105);
    // 6th sample wraps to address 0, sweep starts at 1
    send(16'd6, 16'd106);
    // wrap through 12 samples, including negative data
    send(16'hFED4, 16'd107);
    for (int i = 8; i <= 12; i++) send(16'(i * 37), 16'(200 + i));

    // overrun during SEQ is dropped and sets a sticky flag
    step(1'b1, 16'd13, 16'd113, 1'b1);
    step(1'b0, 16'h0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b0);
    step(1'b1, 16'h7FFF, 16'h7FFF, 1'b0);
    wait_idle();
    send(16'd14, 16'd114);

    // reset in the middle of a sweep
    step(1'b1, 16'd15, 16'd115, 1'b1);
    repeat (3) step(1'b0, 16'h0, 16'h0, 1'b0);
    chk("pre_rst_seq", bus.sequencing, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_sequencing", bus.sequencing, 1'b0);
    chk("midrst_done", bus.done, 1'b0);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_full", bus.full, 1'b0);
    chk("midrst_ovr", bus.ovr, 1'b0);
    clear_model();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(16'h0042, 16'h0043);
    send(16'h0050, 16'h0051);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end
endmodule
